// File: rtl/regfile_pkg.sv
// Shared constants and types for the multiport register file.
package regfile_pkg;

  // Default geometry of the register file.
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int NUM_RD_DEF = 2;

  // Data and address types at the default geometry.
  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-bit scoreboard: one bit per register plus a registered count of
// set bits. A set and a clear of the same register in one cycle resolve to set.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       set_i,
  input  logic [ADDR_W-1:0]          set_addr_i,
  input  logic                       clr0_i,
  input  logic [ADDR_W-1:0]          clr0_addr_i,
  input  logic                       clr1_i,
  input  logic [ADDR_W-1:0]          clr1_addr_i,
  output logic [(1 << ADDR_W)-1:0]   pend_o,
  output logic [ADDR_W:0]            cnt_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             inc, dec0, dec1;

  // Next pending vector and the count delta derived from the same decisions.
  always_comb begin
    pend_d = pend_q;
    if (clr0_i) pend_d[clr0_addr_i] = 1'b0;
    if (clr1_i) pend_d[clr1_addr_i] = 1'b0;
    if (set_i)  pend_d[set_addr_i]  = 1'b1;

    // Count only real transitions: a re-set of a pending bit adds nothing,
    // a clear of an idle bit removes nothing, and a clear overridden by a
    // set of the same register removes nothing.
    inc  = set_i && !pend_q[set_addr_i];
    dec0 = clr0_i && pend_q[clr0_addr_i] &&
           !(set_i && (set_addr_i == clr0_addr_i));
    // Both write ports hitting one register clear it only once.
    dec1 = clr1_i && pend_q[clr1_addr_i] &&
           !(set_i && (set_addr_i == clr1_addr_i)) &&
           !(clr0_i && (clr0_addr_i == clr1_addr_i));

    cnt_d = cnt_q + {{ADDR_W{1'b0}}, inc}
                  - {{ADDR_W{1'b0}}, dec0}
                  - {{ADDR_W{1'b0}}, dec1};
  end

  // Pending bits and count update together so they can never disagree.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_o = pend_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/multiport_regfile.sv
// Two-write, NUM_RD-read register file with same-cycle write bypass,
// optional hard-wired zero register and a pending-write scoreboard.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              wr0_en, wr1_en, wr0_commit, set_en;

  // True for the hard-wired zero register when that feature is enabled.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Effective write/set qualifiers: nothing acts during reset or on the zero
  // register; port 1 owns a shared address, so port 0 drops its data there.
  always_comb begin
    wr0_en     = rst && we0 && !is_zero(waddr0);
    wr1_en     = rst && we1 && !is_zero(waddr1);
    wr0_commit = wr0_en && !(wr1_en && (waddr1 == waddr0));
    set_en     = rst && sb_set && !is_zero(sb_addr);
  end

  // Register storage; the two commits never target the same entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      if (wr0_commit) regs_q[waddr0] <= wdata0;
      if (wr1_en)     regs_q[waddr1] <= wdata1;
    end
  end

  // Combinational read ports with bypass and busy flags.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [ADDR_W-1:0] ra;
      logic              hit0, hit1, set_hit;
      logic [DATA_W-1:0] val;
      ra      = raddr[k*ADDR_W +: ADDR_W];
      hit0    = wr0_en && (waddr0 == ra);
      hit1    = wr1_en && (waddr1 == ra);
      set_hit = set_en && (sb_addr == ra);
      if (!rst || is_zero(ra)) val = '0;
      else if (hit1)           val = wdata1;
      else if (hit0)           val = wdata0;
      else                     val = regs_q[ra];
      rdata[k*DATA_W +: DATA_W] = val;
      // A write in flight retires the pending state early; a simultaneous
      // set on the same register shows the post-edge busy state instead.
      if (!rst)                  rbusy[k] = 1'b0;
      else if (hit0 || hit1)     rbusy[k] = set_hit;
      else                       rbusy[k] = pend[ra];
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk_i       (clk),
    .rst_ni      (rst),
    .set_i       (set_en),
    .set_addr_i  (sb_addr),
    .clr0_i      (wr0_en),
    .clr0_addr_i (waddr0),
    .clr1_i      (wr1_en),
    .clr1_addr_i (waddr1),
    .pend_o      (pend),
    .cnt_o       (pend_cnt)
  );

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench for multiport_regfile: default build plus a wide
// four-read-port build without the zero register.
module tb_multiport_regfile;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- default build ----------------
  logic        we0, we1, sb_set;
  logic [3:0]  waddr0, waddr1, sb_addr;
  logic [15:0] wdata0, wdata1;
  logic [7:0]  raddr;
  logic [31:0] rdata;
  logic [1:0]  rbusy;
  logic [4:0]  pend_cnt;

  multiport_regfile dut (
    .clk      (clk),
    .rst      (rst),
    .we0      (we0),
    .we1      (we1),
    .waddr0   (waddr0),
    .waddr1   (waddr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .pend_cnt (pend_cnt)
  );

  // ---------------- wide build ----------------
  logic         we0_w, we1_w, sb_set_w;
  logic [3:0]   waddr0_w, waddr1_w, sb_addr_w;
  logic [31:0]  wdata0_w, wdata1_w;
  logic [15:0]  raddr_w;
  logic [127:0] rdata_w;
  logic [3:0]   rbusy_w;
  logic [4:0]   pend_cnt_w;

  multiport_regfile #(
    .DATA_W   (32),
    .ADDR_W   (4),
    .NUM_RD   (4),
    .ZERO_REG (0)
  ) dut_w (
    .clk      (clk),
    .rst      (rst),
    .we0      (we0_w),
    .we1      (we1_w),
    .waddr0   (waddr0_w),
    .waddr1   (waddr1_w),
    .wdata0   (wdata0_w),
    .wdata1   (wdata1_w),
    .raddr    (raddr_w),
    .rdata    (rdata_w),
    .rbusy    (rbusy_w),
    .sb_set   (sb_set_w),
    .sb_addr  (sb_addr_w),
    .pend_cnt (pend_cnt_w)
  );

  // ---------------- scoreboard state ----------------
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] rd(input int k);
    return rdata[k*16 +: 16];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    we0 = 1'b0; we1 = 1'b0; sb_set = 1'b0;
  endtask

  task automatic set_raddr(input logic [3:0] a0, input logic [3:0] a1);
    raddr = {a1, a0};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    we0 = 1'b1; waddr0 = 4'd3; wdata0 = 16'h1234;
    sb_set = 1'b1; sb_addr = 4'd3;
    set_raddr(4'd3, 4'd3);
    #1;
    vec_cnt++; if (rdata !== 32'h0) begin err_cnt++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0); end
    vec_cnt++; if (rbusy !== 2'b00) begin err_cnt++; $display("FAIL reset_rbusy: got %b expected %b", rbusy, 2'b00); end
    vec_cnt++; if (pend_cnt !== 5'd0) begin err_cnt++; $display("FAIL reset_cnt: got %0d expected %0d", pend_cnt, 0); end
    @(posedge clk); #1;
    vec_cnt++; if (pend_cnt !== 5'd0) begin err_cnt++; $display("FAIL reset_cnt_edge: got %0d expected %0d", pend_cnt, 0); end
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    #1;
    vec_cnt++; if (rd(0) !== 16'h0) begin err_cnt++; $display("FAIL reset_write_ignored: got %h expected %h", rd(0), 16'h0); end
    vec_cnt++; if (rbusy !== 2'b00) begin err_cnt++; $display("FAIL reset_set_ignored: got %b expected %b", rbusy, 2'b00); end
    @(posedge clk); #1;
    vec_cnt++; if (pend_cnt !== 5'd0) begin err_cnt++; $display("FAIL reset_cnt_after: got %0d expected %0d", pend_cnt, 0); end
  endtask

  task automatic test_fill();
    logic [15:0] exp;
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      we0 = 1'b1; waddr0 = 4'(r);
      wdata0 = (r % 2 == 0) ? 16'hDEAD : 16'hBEEF;
      set_raddr(4'(r), 4'(r));
      exp = (r == 0) ? 16'h0 : wdata0;
      exp_q.push_back(exp);
      #1;
      vec_cnt++; if (rd(0) !== exp) begin err_cnt++; $display("FAIL fill_bypass_p0 r=%0d: got %h expected %h", r, rd(0), exp); end
      vec_cnt++; if (rd(1) !== exp) begin err_cnt++; $display("FAIL fill_bypass_p1 r=%0d: got %h expected %h", r, rd(1), exp); end
    end
    @(negedge clk);
    drive_idle();
    for (int r = 0; r < 16; r++) begin
      set_raddr(4'(r), 4'(15 - r));
      #1;
      vec_cnt++; if (rd(0) !== exp_q[r]) begin err_cnt++; $display("FAIL fill_read_p0 r=%0d: got %h expected %h", r, rd(0), exp_q[r]); end
      vec_cnt++; if (rd(1) !== exp_q[15-r]) begin err_cnt++; $display("FAIL fill_read_p1 r=%0d: got %h expected %h", 15 - r, rd(1), exp_q[15-r]); end
    end
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    we0 = 1'b1; waddr0 = 4'd5; wdata0 = 16'h1111;
    we1 = 1'b1; waddr1 = 4'd5; wdata1 = 16'h2222;
    set_raddr(4'd5, 4'd4);
    #1;
    vec_cnt++; if (rd(0) !== 16'h2222) begin err_cnt++; $display("FAIL dual_bypass: got %h expected %h", rd(0), 16'h2222); end
    vec_cnt++; if (rd(1) !== 16'hDEAD) begin err_cnt++; $display("FAIL dual_other_port: got %h expected %h", rd(1), 16'hDEAD); end
    @(negedge clk);
    drive_idle();
    #1;
    vec_cnt++; if (rd(0) !== 16'h2222) begin err_cnt++; $display("FAIL dual_commit: got %h expected %h", rd(0), 16'h2222); end
    // Distinct addresses on both ports commit independently.
    @(negedge clk);
    we0 = 1'b1; waddr0 = 4'd10; wdata0 = 16'hAAAA;
    we1 = 1'b1; waddr1 = 4'd11; wdata1 = 16'hBBBB;
    @(negedge clk);
    drive_idle();
    set_raddr(4'd10, 4'd11);
    #1;
    vec_cnt++; if (rdata !== 32'hBBBB_AAAA) begin err_cnt++; $display("FAIL dual_distinct: got %h expected %h", rdata, 32'hBBBB_AAAA); end
  endtask

  task automatic test_scoreboard();
    vec_cnt++; if (pend_cnt !== 5'd0) begin err_cnt++; $display("FAIL sb_start: got %0d expected %0d", pend_cnt, 0); end
    @(negedge clk);
    sb_set = 1'b1; sb_addr = 4'd3;
    @(posedge clk); #1;
    vec_cnt++; if (pend_cnt !== 5'd1) begin err_cnt++; $display("FAIL sb_set3: got %0d expected %0d", pend_cnt, 1); end
    @(negedge clk);
    sb_addr = 4'd7;
    @(posedge clk); #1;
    vec_cnt++; if (pend_cnt !== 5'd2) begin err_cnt++; $display("FAIL sb_set7: got %0d expected %0d", pend_cnt, 2); end
    @(negedge clk);
    sb_addr = 4'd7;
    @(posedge clk); #1;
    vec_cnt++; if (pend_cnt !== 5'd2) begin err_cnt++; $display("FAIL sb_reset7: got %0d expected %0d", pend_cnt, 2); end
    @(negedge clk);
    drive_idle();
    set_raddr(4'd7, 4'd3);
    #1;
    vec_cnt++; if (rbusy !== 2'b11) begin err_cnt++; $display("FAIL sb_busy: got %b expected %b", rbusy, 2'b11); end
    @(negedge clk);
    we0 = 1'b1; waddr0 = 4'd7; wdata0 = 16'h7777;
    #1;
    vec_cnt++; if (rbusy !== 2'b10) begin err_cnt++; $display("FAIL sb_write_clears_busy: got %b expected %b", rbusy, 2'b10); end
    vec_cnt++; if (rd(0) !== 16'h7777) begin err_cnt++; $display("FAIL sb_write_bypass: got %h expected %h", rd(0), 16'h7777); end
    @(posedge clk); #1;
    vec_cnt++; if (pend_cnt !== 5'd1) begin err_cnt++; $display("FAIL sb_write_cnt: got %0d expected %0d", pend_cnt, 1); end
    @(negedge clk);
    drive_idle();
    #1;
    vec_cnt++; if (rbusy !== 2'b10) begin err_cnt++; $display("FAIL sb_after_write_busy: got %b expected %b", rbusy, 2'b10); end
  endtask

  task automatic test_set_and_write();
    @(negedge clk);
    sb_set = 1'b1; sb_addr = 4'd9;
    we1 = 1'b1; waddr1 = 4'd9; wdata1 = 16'h9999;
    set_raddr(4'd9, 4'd3);
    #1;
    vec_cnt++; if (rbusy !== 2'b11) begin err_cnt++; $display("FAIL setwr_busy: got %b expected %b", rbusy, 2'b11); end
    vec_cnt++; if (rd(0) !== 16'h9999) begin err_cnt++; $display("FAIL setwr_bypass: got %h expected %h", rd(0), 16'h9999); end
    @(posedge clk); #1;
    vec_cnt++; if (pend_cnt !== 5'd2) begin err_cnt++; $display("FAIL setwr_cnt: got %0d expected %0d", pend_cnt, 2); end
    @(negedge clk);
    drive_idle();
    #1;
    vec_cnt++; if (rbusy !== 2'b11) begin err_cnt++; $display("FAIL setwr_busy_after: got %b expected %b", rbusy, 2'b11); end
    // Both ports retire a pending register each: count drops by two.
    @(negedge clk);
    we0 = 1'b1; waddr0 = 4'd3; wdata0 = 16'h3333;
    we1 = 1'b1; waddr1 = 4'd9; wdata1 = 16'h9A9A;
    #1;
    vec_cnt++; if (rbusy !== 2'b00) begin err_cnt++; $display("FAIL dual_clear_busy: got %b expected %b", rbusy, 2'b00); end
    @(posedge clk); #1;
    vec_cnt++; if (pend_cnt !== 5'd0) begin err_cnt++; $display("FAIL dual_clear_cnt: got %0d expected %0d", pend_cnt, 0); end
    @(negedge clk);
    drive_idle();
    #1;
    vec_cnt++; if (rdata !== 32'h3333_9A9A) begin err_cnt++; $display("FAIL dual_clear_data: got %h expected %h", rdata, 32'h3333_9A9A); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    sb_set = 1'b1; sb_addr = 4'd0;
    we0 = 1'b1; waddr0 = 4'd0; wdata0 = 16'hFFFF;
    we1 = 1'b1; waddr1 = 4'd0; wdata1 = 16'hEEEE;
    set_raddr(4'd0, 4'd0);
    #1;
    vec_cnt++; if (rdata !== 32'h0) begin err_cnt++; $display("FAIL zero_bypass: got %h expected %h", rdata, 32'h0); end
    vec_cnt++; if (rbusy !== 2'b00) begin err_cnt++; $display("FAIL zero_busy: got %b expected %b", rbusy, 2'b00); end
    @(posedge clk); #1;
    vec_cnt++; if (pend_cnt !== 5'd0) begin err_cnt++; $display("FAIL zero_cnt: got %0d expected %0d", pend_cnt, 0); end
    @(negedge clk);
    drive_idle();
    #1;
    vec_cnt++; if (rdata !== 32'h0) begin err_cnt++; $display("FAIL zero_read: got %h expected %h", rdata, 32'h0); end
  endtask

  task automatic test_async_reset();
    logic [3:0] pend_list [4];
    pend_list[0] = 4'd1; pend_list[1] = 4'd2; pend_list[2] = 4'd4; pend_list[3] = 4'd6;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sb_set = 1'b1; sb_addr = pend_list[i];
    end
    @(negedge clk);
    drive_idle();
    set_raddr(4'd5, 4'd2);
    #1;
    vec_cnt++; if (pend_cnt !== 5'd4) begin err_cnt++; $display("FAIL areset_pre_cnt: got %0d expected %0d", pend_cnt, 4); end
    vec_cnt++; if (rbusy !== 2'b10) begin err_cnt++; $display("FAIL areset_pre_busy: got %b expected %b", rbusy, 2'b10); end
    vec_cnt++; if (rd(0) !== 16'h2222) begin err_cnt++; $display("FAIL areset_pre_data: got %h expected %h", rd(0), 16'h2222); end
    // Drop reset between edges and look before the next rising edge.
    #1 rst = 1'b0;
    #1;
    vec_cnt++; if (rdata !== 32'h0) begin err_cnt++; $display("FAIL areset_rdata: got %h expected %h", rdata, 32'h0); end
    vec_cnt++; if (rbusy !== 2'b00) begin err_cnt++; $display("FAIL areset_rbusy: got %b expected %b", rbusy, 2'b00); end
    vec_cnt++; if (pend_cnt !== 5'd0) begin err_cnt++; $display("FAIL areset_cnt: got %0d expected %0d", pend_cnt, 0); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vec_cnt++; if (rdata !== 32'h0) begin err_cnt++; $display("FAIL areset_cleared: got %h expected %h", rdata, 32'h0); end
    vec_cnt++; if (rbusy !== 2'b00) begin err_cnt++; $display("FAIL areset_busy_cleared: got %b expected %b", rbusy, 2'b00); end
  endtask

  task automatic test_count_max();
    for (int a = 1; a < 16; a++) begin
      @(negedge clk);
      sb_set = 1'b1; sb_addr = 4'(a);
      @(posedge clk); #1;
      vec_cnt++; if (pend_cnt !== 5'(a)) begin err_cnt++; $display("FAIL cnt_fill a=%0d: got %0d expected %0d", a, pend_cnt, a); end
    end
    @(negedge clk);
    sb_addr = 4'd15;
    @(posedge clk); #1;
    vec_cnt++; if (pend_cnt !== 5'd15) begin err_cnt++; $display("FAIL cnt_max_hold: got %0d expected %0d", pend_cnt, 15); end
    @(negedge clk);
    drive_idle();
    we0 = 1'b1; waddr0 = 4'd1; wdata0 = 16'h0101;
    we1 = 1'b1; waddr1 = 4'd2; wdata1 = 16'h0202;
    @(posedge clk); #1;
    vec_cnt++; if (pend_cnt !== 5'd13) begin err_cnt++; $display("FAIL cnt_max_drop2: got %0d expected %0d", pend_cnt, 13); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_wide();
    @(negedge clk);
    we0_w = 1'b1; waddr0_w = 4'd0; wdata0_w = 32'hCAFEF00D;
    raddr_w = {4'd0, 4'd0, 4'd0, 4'd0};
    #1;
    for (int k = 0; k < 4; k++) begin
      vec_cnt++; if (rdata_w[k*32 +: 32] !== 32'hCAFEF00D) begin err_cnt++; $display("FAIL wide_bypass p%0d: got %h expected %h", k, rdata_w[k*32 +: 32], 32'hCAFEF00D); end
    end
    @(negedge clk);
    we0_w = 1'b0;
    sb_set_w = 1'b1; sb_addr_w = 4'd0;
    #1;
    for (int k = 0; k < 4; k++) begin
      vec_cnt++; if (rdata_w[k*32 +: 32] !== 32'hCAFEF00D) begin err_cnt++; $display("FAIL wide_read p%0d: got %h expected %h", k, rdata_w[k*32 +: 32], 32'hCAFEF00D); end
    end
    @(posedge clk); #1;
    vec_cnt++; if (pend_cnt_w !== 5'd1) begin err_cnt++; $display("FAIL wide_reg0_set: got %0d expected %0d", pend_cnt_w, 1); end
    @(negedge clk);
    sb_set_w = 1'b0;
    #1;
    vec_cnt++; if (rbusy_w !== 4'hF) begin err_cnt++; $display("FAIL wide_reg0_busy: got %b expected %b", rbusy_w, 4'hF); end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt + 1);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence / report ----------------
  initial begin
    rst = 1'b0;
    drive_idle();
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    sb_addr = '0; raddr = '0;
    we0_w = 1'b0; we1_w = 1'b0; sb_set_w = 1'b0;
    waddr0_w = '0; waddr1_w = '0; wdata0_w = '0; wdata1_w = '0;
    sb_addr_w = '0; raddr_w = '0;

    test_reset();
    test_fill();
    test_dual_write();
    test_scoreboard();
    test_set_and_write();
    test_zero_reg();
    test_async_reset();
    test_count_max();
    test_wide();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
